// File: rtl/cpu4_sequencer_if.sv
// Sequencer bus: program load, run control, datapath issue handshake and status.
// The slave modport is the sequencer side; the master modport is the controller/datapath side.
interface cpu4_sequencer_if;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_wdata;
  logic       start;
  logic       halt_req;
  logic       issue_valid;
  logic [3:0] issue_opcode;
  logic [3:0] issue_operand;
  logic       issue_ready;
  logic       acc_zero;
  logic [3:0] pc;
  logic       busy;
  logic       done;

  modport slave (
    input  prog_we, prog_addr, prog_wdata, start, halt_req, issue_ready, acc_zero,
    output issue_valid, issue_opcode, issue_operand, pc, busy, done
  );

  modport master (
    output prog_we, prog_addr, prog_wdata, start, halt_req, issue_ready, acc_zero,
    input  issue_valid, issue_opcode, issue_operand, pc, busy, done
  );
endinterface

// File: rtl/cpu4_sequencer.sv
// 4-bit CPU instruction sequencer: 16-word program store, fetch/issue FSM, HALT handling.
// Optional macro SEQ_BRANCH_EN makes JMP (0xB) and JZ (0xC) resolve inside the sequencer.
module cpu4_sequencer #(
  parameter int unsigned PROG_DEPTH = 16
) (
  input logic             clk,
  input logic             rst,
  cpu4_sequencer_if.slave bus_io
);
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StIssue = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [3:0] OpHalt = 4'hF;
`ifdef SEQ_BRANCH_EN
  localparam logic [3:0] OpJmp  = 4'hB;
  localparam logic [3:0] OpJz   = 4'hC;
`endif

  logic [1:0] state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] instr_q, instr_d;
  logic [7:0] mem_q [PROG_DEPTH];

  logic [3:0] op;
  logic [3:0] pc_inc;
  logic       is_halt;
  logic       is_branch;
  logic [3:0] branch_pc;
  logic       valid;

  assign op      = instr_q[7:4];
  assign pc_inc  = pc_q + 4'd1;
  assign is_halt = (op == OpHalt);

`ifdef SEQ_BRANCH_EN
  assign is_branch = (op == OpJmp) || (op == OpJz);
  assign branch_pc = ((op == OpJz) && !bus_io.acc_zero) ? pc_inc : instr_q[3:0];
`else
  assign is_branch = 1'b0;
  assign branch_pc = pc_inc;
`endif

  // HALT and branches are consumed here and never reach the datapath.
  assign valid = (state_q == StIssue) && !is_halt && !is_branch;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          state_d = StFetch;
          pc_d    = 4'd0;
        end
      end
      StFetch: begin
        if (bus_io.halt_req) begin
          state_d = StDone;
        end else begin
          instr_d = mem_q[pc_q];
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (is_halt) begin
          state_d = StDone;
        end else if (is_branch) begin
          pc_d    = branch_pc;
          state_d = bus_io.halt_req ? StDone : StFetch;
        end else if (bus_io.issue_ready) begin
          // halt_req only matters once the pending instruction has been accepted.
          pc_d    = pc_inc;
          state_d = bus_io.halt_req ? StDone : StFetch;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= 4'd0;
      instr_q <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Program store survives reset; loads are accepted only while idle.
  always_ff @(posedge clk) begin
    if (bus_io.prog_we && (state_q == StIdle)) begin
      mem_q[bus_io.prog_addr] <= bus_io.prog_wdata;
    end
  end

  assign bus_io.issue_valid   = valid;
  assign bus_io.issue_opcode  = instr_q[7:4];
  assign bus_io.issue_operand = instr_q[3:0];
  assign bus_io.pc            = pc_q;
  assign bus_io.busy          = (state_q != StIdle);
  assign bus_io.done          = (state_q == StDone);
endmodule

// File: tb/tb_cpu4_sequencer.sv
// Directed self-checking bench for cpu4_sequencer: program runs, stalls, halts, wrap, reset.
module tb_cpu4_sequencer;
  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_fail;

  cpu4_sequencer_if bus ();

  cpu4_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [3:0] addr, input logic [7:0] data);
    bus.prog_we    = 1'b1;
    bus.prog_addr  = addr;
    bus.prog_wdata = data;
    tick();
    bus.prog_we    = 1'b0;
  endtask

  task automatic load_prog();
    write_word(4'd0, 8'h32);
    write_word(4'd1, 8'h05);
    write_word(4'd2, 8'hF0);
  endtask

  task automatic check_issue(input string tag, input logic [3:0] opc, input logic [3:0] opd);
    check_eq({tag, "_valid"}, 32'(bus.issue_valid), 1);
    check_eq({tag, "_opcode"}, 32'(bus.issue_opcode), 32'(opc));
    check_eq({tag, "_operand"}, 32'(bus.issue_operand), 32'(opd));
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = 4'd0;
    bus.prog_wdata = 8'h00;
    bus.start      = 1'b0;
    bus.halt_req   = 1'b0;
    bus.issue_ready = 1'b1;
    bus.acc_zero   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(bus.issue_valid), 0);
    check_eq("rst_opcode", 32'(bus.issue_opcode), 0);
    check_eq("rst_operand", 32'(bus.issue_operand), 0);
    check_eq("rst_pc", 32'(bus.pc), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_done", 32'(bus.done), 0);
    rst = 1'b0;

    // Basic run, ready always high.
    load_prog();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("run_fetch_busy", 32'(bus.busy), 1);
    check_eq("run_fetch_valid", 32'(bus.issue_valid), 0);
    check_eq("run_fetch_pc", 32'(bus.pc), 0);
    tick();
    check_issue("run_i0", 4'h3, 4'h2);
    tick();
    check_eq("run_pc1", 32'(bus.pc), 1);
    check_eq("run_gap_valid", 32'(bus.issue_valid), 0);
    tick();
    check_issue("run_i1", 4'h0, 4'h5);
    tick();
    tick();
    check_eq("run_halt_noissue", 32'(bus.issue_valid), 0);
    tick();
    check_eq("run_done", 32'(bus.done), 1);
    check_eq("run_done_pc", 32'(bus.pc), 2);
    tick();
    check_eq("run_idle_done", 32'(bus.done), 0);
    check_eq("run_idle_busy", 32'(bus.busy), 0);

    // Stall first issue for three cycles.
    bus.issue_ready = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.issue_ready = (i == 3);
      check_issue("stall_hold", 4'h3, 4'h2);
      check_eq("stall_pc", 32'(bus.pc), 0);
      tick();
    end
    check_eq("stall_accept_pc", 32'(bus.pc), 1);
    tick();
    check_issue("stall_i1", 4'h0, 4'h5);
    repeat (3) tick();
    check_eq("stall_done", 32'(bus.done), 1);
    tick();

    // halt_req during a stalled issue: one acceptance, then DONE.
    bus.issue_ready = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.halt_req = 1'b1;
    tick();
    check_issue("hstall_hold", 4'h3, 4'h2);
    check_eq("hstall_done0", 32'(bus.done), 0);
    bus.issue_ready = 1'b1;
    tick();
    check_eq("hstall_done", 32'(bus.done), 1);
    check_eq("hstall_valid", 32'(bus.issue_valid), 0);
    bus.halt_req = 1'b0;
    tick();
    check_eq("hstall_idle_done", 32'(bus.done), 0);
    check_eq("hstall_idle_busy", 32'(bus.busy), 0);

    // halt_req in FETCH.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.halt_req = 1'b1;
    tick();
    check_eq("hfetch_done", 32'(bus.done), 1);
    check_eq("hfetch_pc", 32'(bus.pc), 0);
    check_eq("hfetch_valid", 32'(bus.issue_valid), 0);
    bus.halt_req = 1'b0;
    tick();

    // Write and start on the same edge: first fetch sees the new word.
    bus.issue_ready = 1'b0;
    bus.prog_we    = 1'b1;
    bus.prog_addr  = 4'd0;
    bus.prog_wdata = 8'h7A;
    bus.start      = 1'b1;
    tick();
    bus.prog_we = 1'b0;
    bus.start   = 1'b0;
    tick();
    check_issue("wrstart", 4'h7, 4'hA);
    bus.issue_ready = 1'b1;
    tick();
    bus.halt_req = 1'b1;
    tick();
    check_eq("wrstart_done", 32'(bus.done), 1);
    bus.halt_req = 1'b0;
    tick();

    // Branch opcode handling.
    write_word(4'd0, 8'hC3);
    bus.acc_zero = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
`ifdef SEQ_BRANCH_EN
    check_eq("jz_taken_valid", 32'(bus.issue_valid), 0);
    tick();
    check_eq("jz_taken_pc", 32'(bus.pc), 3);
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    tick();
    bus.acc_zero = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check_eq("jz_nt_valid", 32'(bus.issue_valid), 0);
    tick();
    check_eq("jz_nt_pc", 32'(bus.pc), 1);
`else
    check_issue("jz_issued", 4'hC, 4'h3);
    tick();
    check_eq("jz_issued_pc", 32'(bus.pc), 1);
`endif
    bus.halt_req = 1'b1;
    tick();
    check_eq("br_done", 32'(bus.done), 1);
    bus.halt_req = 1'b0;
    tick();

    // All-zero program wraps the pc with no HALT.
    for (int a = 0; a < 16; a++) write_word(4'(a), 8'h00);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 18; k++) begin
      check_eq("wrap_pc", 32'(bus.pc), 32'(k % 16));
      check_eq("wrap_busy", 32'(bus.busy), 1);
      tick();
      tick();
    end
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    tick();

    // Reset mid-ISSUE; write while busy is ignored; program retained.
    load_prog();
    bus.issue_ready = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start      = 1'b0;
    bus.prog_we    = 1'b1;
    bus.prog_addr  = 4'd1;
    bus.prog_wdata = 8'hF0;
    tick();
    bus.prog_we = 1'b0;
    check_issue("rstmid_pre", 4'h3, 4'h2);
    rst = 1'b1;
    #1;
    check_eq("rstmid_valid", 32'(bus.issue_valid), 0);
    check_eq("rstmid_pc", 32'(bus.pc), 0);
    check_eq("rstmid_busy", 32'(bus.busy), 0);
    #1;
    rst = 1'b0;
    bus.issue_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check_issue("rerun_i0", 4'h3, 4'h2);
    tick();
    tick();
    check_issue("rerun_i1", 4'h0, 4'h5);
    repeat (3) tick();
    check_eq("rerun_done", 32'(bus.done), 1);
    check_eq("rerun_pc", 32'(bus.pc), 2);
    tick();
    check_eq("rerun_idle", 32'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu4_sequencer.md
CPU4_SEQUENCER -- requirements
Module: cpu4_sequencer

Interface
REQ-001 Parameter: PROG_DEPTH, default 16, number of 8-bit program words; fixed at 16 so the PC is 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 prog_we  input  1  program-memory write strobe.
REQ-005 prog_addr  input  4  program-memory write address.
REQ-006 prog_wdata  input  8  instruction word: [7:4] opcode, [3:0] operand.
REQ-007 start  input  1  level, sampled each cycle; begin execution at PC=0.
REQ-008 halt_req  input  1  request early stop.
REQ-009 issue_valid  output  1  instruction presented to the datapath.
REQ-010 issue_opcode  output  4  opcode to the datapath.
REQ-011 issue_operand  output  4  data/address operand to the datapath.
REQ-012 issue_ready  input  1  datapath accepts the instruction this cycle.
REQ-013 acc_zero  input  1  datapath accumulator equals 4'b0000.
REQ-014 pc  output  4  current program counter.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse when execution ends.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, ISSUE, DONE.
- IDLE->FETCH when start=1; pc<=0.
- FETCH->ISSUE after one cycle of registered program-memory read at pc.
- ISSUE holds until issue_valid && issue_ready; then pc<=pc+1 and ->FETCH.
- DONE->IDLE unconditionally.
REQ-018 Latency SHALL be: start sampled at edge N -> FETCH at N+1 -> issue_valid=1 from N+2.
REQ-019 issue_valid SHALL be 1 only in ISSUE; issue_opcode/issue_operand SHALL stay stable while issue_valid=1 and issue_ready=0.
REQ-020 Opcode 4'b1111 (HALT) SHALL NOT be issued; in ISSUE it causes ->DONE with pc unchanged.
REQ-021 pc SHALL wrap from 15 to 0 on increment; execution continues, with no error.
REQ-022 prog_we SHALL write prog_wdata to prog_addr only when busy=0; writes while busy=1 SHALL be ignored.
REQ-023 If prog_we and start are both 1 in IDLE, the write SHALL complete at the same edge, and the first FETCH SHALL observe the new word.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 halt_req in FETCH SHALL cause ->DONE. In ISSUE it SHALL take effect only after the pending handshake completes, giving ->DONE instead of ->FETCH. Neither case is ever an abandoned issue_valid.
REQ-026 done SHALL be 1 exactly during the DONE state.

Reset
REQ-027 On rst=1, asynchronously: state=IDLE, pc=0, issue_valid=0, issue_opcode=0, issue_operand=0, busy=0, done=0.
REQ-028 Program memory SHALL NOT be cleared by rst.
REQ-029 Reset during ISSUE SHALL drop issue_valid immediately, and no instruction SHALL be considered accepted.

Configuration
REQ-030 Macro SEQ_BRANCH_EN defined: opcodes are handled inside the sequencer in ISSUE, are never issued, and take one cycle:
- 4'b1011 JMP: pc<=operand.
- 4'b1100 JZ: pc<=operand if acc_zero=1, else pc+1.
- Next state is FETCH, or DONE if halt_req=1.
REQ-031 Macro SEQ_BRANCH_EN undefined: 4'b1011 and 4'b1100 SHALL be issued to the datapath like any other opcode.

Verification
REQ-032 Load {0x3_2, 0x0_5, 0xF_0}, start, issue_ready=1 -> issues (3,2) at cycle 2 and (0,5) at cycle 4, then done pulse; pc=2 at done.
REQ-033 Same program, issue_ready held 0 for 3 cycles on the first issue -> (3,2) is held stable with issue_valid=1 for 4 cycles; pc stays 0 until acceptance.
REQ-034 Memory all 0x00 except word 15=0x00, no HALT -> pc sequence ...14, 15, 0, 1; busy stays 1.
REQ-035 halt_req asserted while ISSUE is stalled with issue_ready=0, then issue_ready=1 -> one acceptance, then DONE, done=1 for one cycle, back to IDLE.
REQ-036 With SEQ_BRANCH_EN: word0=0xC_3, acc_zero=1 -> next fetch at pc=3, no issue_valid for word0. With acc_zero=0 -> fetch at pc=1.
REQ-037 Assert rst mid-ISSUE -> issue_valid=0, pc=0, busy=0 without waiting for a clock edge; a subsequent start re-runs the retained program from pc=0.
